// File: rtl/ctrl_sequencer_if.sv
// Decode-stage handshake between the fetch/hazard logic and ctrl_sequencer.
// The master drives opcode and pipeline controls; the slave returns the control bundle.
interface ctrl_sequencer_if #(
  parameter int OPW  = 5,
  parameter int ALUW = 4,
  parameter int CW   = 2
);
  logic [OPW-1:0]  opcode;
  logic            instr_valid;
  logic            stall;
  logic            nop_in;
  logic            squash;
  logic [9:0]      ctrl;
  logic [ALUW-1:0] alu_op;
  logic            shift;
  logic [1:0]      push_pop;
  logic            imm_phase;
  logic            pc_hold;
  logic            busy;
  logic            illegal;
  logic [CW-1:0]   flush_cnt;

  modport master (
    output opcode, instr_valid, stall, nop_in, squash,
    input  ctrl, alu_op, shift, push_pop, imm_phase, pc_hold, busy, illegal, flush_cnt
  );

  modport slave (
    input  opcode, instr_valid, stall, nop_in, squash,
    output ctrl, alu_op, shift, push_pop, imm_phase, pc_hold, busy, illegal, flush_cnt
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// ID-stage decode-and-sequence unit: opcode to registered control bundle, with
// LDM immediate-word sequencing and RET/RTI flush-bubble counting in one FSM.
package ctrl_sequencer_pkg;
  localparam logic [4:0] OP_NOP  = 5'd0,  OP_SETC = 5'd1,  OP_CLRC = 5'd2,  OP_NOT  = 5'd3;
  localparam logic [4:0] OP_INC  = 5'd4,  OP_DEC  = 5'd5,  OP_OUT  = 5'd6,  OP_IN   = 5'd7;
  localparam logic [4:0] OP_MOV  = 5'd8,  OP_ADD  = 5'd9,  OP_SUB  = 5'd10, OP_AND  = 5'd11;
  localparam logic [4:0] OP_OR   = 5'd12, OP_SHL  = 5'd13, OP_SHR  = 5'd14, OP_PUSH = 5'd15;
  localparam logic [4:0] OP_POP  = 5'd16, OP_LDM  = 5'd17, OP_LDD  = 5'd18, OP_STD  = 5'd19;
  localparam logic [4:0] OP_JZ   = 5'd20, OP_JN   = 5'd21, OP_JC   = 5'd22, OP_JMP  = 5'd23;
  localparam logic [4:0] OP_CALL = 5'd24, OP_RET  = 5'd25, OP_RTI  = 5'd26, OP_INT  = 5'd27;
  localparam logic [4:0] OP_RST  = 5'd28;

  localparam logic [3:0] ALU_NOP = 4'd0,  ALU_NOT = 4'd1,  ALU_INC = 4'd2,  ALU_DEC  = 4'd3;
  localparam logic [3:0] ALU_MOV = 4'd4,  ALU_ADD = 4'd5,  ALU_SUB = 4'd6,  ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_OR  = 4'd8,  ALU_SHL = 4'd9,  ALU_SHR = 4'd10, ALU_LDD  = 4'd11;
  localparam logic [3:0] ALU_STD = 4'd12, ALU_JMP = 4'd13, ALU_SETC = 4'd14;

  // ctrl bit order {IR,IW,MR,MW,MTR,ALU_src,RW,Branch,SetC,CLRC}
  localparam logic [9:0] CB_IR  = 10'h200, CB_IW  = 10'h100, CB_MR  = 10'h080, CB_MW   = 10'h040;
  localparam logic [9:0] CB_MTR = 10'h020, CB_SRC = 10'h010, CB_RW  = 10'h008, CB_BR   = 10'h004;
  localparam logic [9:0] CB_SETC = 10'h002, CB_CLRC = 10'h001;

  localparam logic [9:0] ALU_SIGNALS = CB_RW;
  localparam logic [9:0] LOAD_SIGNALS = CB_MR | CB_MTR | CB_RW;
  localparam logic [9:0] IMM_SIGNALS = CB_SRC | CB_RW;
endpackage

module ctrl_sequencer
  import ctrl_sequencer_pkg::*;
#(
  parameter int OPW       = 5,
  parameter int ALUW      = 4,
  parameter int IMM_WORDS = 1,
  parameter int RET_FLUSH = 2,
  parameter int RTI_FLUSH = 3
) (
  input  logic               clk,
  input  logic               rst,
  ctrl_sequencer_if.slave    bus
);
  localparam int MAX_A = (IMM_WORDS > RET_FLUSH) ? IMM_WORDS : RET_FLUSH;
  localparam int MAX_C = (MAX_A > RTI_FLUSH) ? MAX_A : RTI_FLUSH;
  localparam int CW    = $clog2(MAX_C + 1);
  localparam logic [CW-1:0] ONE = 1;

  typedef enum logic [1:0] {S_DECODE, S_IMM, S_FLUSH} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_dec;
  logic [9:0]      ctrl_q;
  logic [ALUW-1:0] alu_q;
  logic            shift_q;
  logic [1:0]      pp_q;
  logic            imm_q;
  logic            pch_q;
  logic            ill_q;

  logic [9:0]      dec_ctrl;
  logic [ALUW-1:0] dec_alu;
  logic            dec_shift;
  logic [1:0]      dec_pp;
  logic            dec_legal;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec_ctrl  = '0;
    dec_alu   = ALUW'(ALU_NOP);
    dec_shift = 1'b0;
    dec_pp    = 2'b00;
    dec_legal = 1'b1;
    case (bus.opcode)
      OPW'(OP_NOT):  begin dec_ctrl = ALU_SIGNALS; dec_alu = ALUW'(ALU_NOT); end
      OPW'(OP_INC):  begin dec_ctrl = ALU_SIGNALS; dec_alu = ALUW'(ALU_INC); end
      OPW'(OP_DEC):  begin dec_ctrl = ALU_SIGNALS; dec_alu = ALUW'(ALU_DEC); end
      OPW'(OP_MOV):  begin dec_ctrl = ALU_SIGNALS; dec_alu = ALUW'(ALU_MOV); end
      OPW'(OP_ADD):  begin dec_ctrl = ALU_SIGNALS; dec_alu = ALUW'(ALU_ADD); end
      OPW'(OP_SUB):  begin dec_ctrl = ALU_SIGNALS; dec_alu = ALUW'(ALU_SUB); end
      OPW'(OP_AND):  begin dec_ctrl = ALU_SIGNALS; dec_alu = ALUW'(ALU_AND); end
      OPW'(OP_OR):   begin dec_ctrl = ALU_SIGNALS; dec_alu = ALUW'(ALU_OR);  end
      OPW'(OP_SHL):  begin dec_ctrl = ALU_SIGNALS; dec_alu = ALUW'(ALU_SHL); dec_shift = 1'b1; end
      OPW'(OP_SHR):  begin dec_ctrl = ALU_SIGNALS; dec_alu = ALUW'(ALU_SHR); dec_shift = 1'b1; end
      OPW'(OP_PUSH): begin dec_ctrl = CB_MW; dec_alu = ALUW'(ALU_MOV); dec_pp = 2'b01; end
      OPW'(OP_POP):  begin dec_ctrl = LOAD_SIGNALS; dec_alu = ALUW'(ALU_MOV); dec_pp = 2'b11; end
      OPW'(OP_LDD):  begin dec_ctrl = LOAD_SIGNALS; dec_alu = ALUW'(ALU_LDD); end
      OPW'(OP_STD):  begin dec_ctrl = CB_MW; dec_alu = ALUW'(ALU_STD); end
      OPW'(OP_JZ), OPW'(OP_JN), OPW'(OP_JC), OPW'(OP_JMP):
                     begin dec_ctrl = CB_BR; dec_alu = ALUW'(ALU_JMP); end
      OPW'(OP_CALL), OPW'(OP_RET), OPW'(OP_RTI):
                     dec_ctrl = CB_BR;
      OPW'(OP_INT):  dec_ctrl = CB_MW | CB_BR;
      OPW'(OP_OUT):  begin dec_ctrl = CB_IW; dec_alu = ALUW'(ALU_MOV); end
      OPW'(OP_IN):   begin dec_ctrl = CB_IR | CB_RW; dec_alu = ALUW'(ALU_MOV); end
      OPW'(OP_SETC): begin dec_ctrl = CB_SETC; dec_alu = ALUW'(ALU_SETC); end
      OPW'(OP_CLRC): dec_ctrl = CB_CLRC;
      OPW'(OP_NOP), OPW'(OP_RST), OPW'(OP_LDM): begin end
      default:       dec_legal = 1'b0;
    endcase
  end

  // Saturating decrement: the counter never wraps below zero.
  assign cnt_dec = (cnt != '0) ? cnt - ONE : '0;

  // NOTE: sequential state uses non-blocking assignments only, so later defaults
  // in this block are simply overridden by the more specific branch below them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_DECODE;
      cnt     <= '0;
      ctrl_q  <= '0;
      alu_q   <= ALUW'(ALU_NOP);
      shift_q <= 1'b0;
      pp_q    <= 2'b00;
      imm_q   <= 1'b0;
      pch_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else if (bus.squash) begin
      state   <= S_DECODE;
      cnt     <= '0;
      ctrl_q  <= '0;
      alu_q   <= ALUW'(ALU_NOP);
      shift_q <= 1'b0;
      pp_q    <= 2'b00;
      imm_q   <= 1'b0;
      pch_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else if (!bus.stall) begin
      ctrl_q  <= '0;
      alu_q   <= ALUW'(ALU_NOP);
      shift_q <= 1'b0;
      pp_q    <= 2'b00;
      imm_q   <= 1'b0;
      pch_q   <= 1'b0;
      ill_q   <= 1'b0;
      if (!bus.nop_in) begin
        case (state)
          S_DECODE: if (bus.instr_valid) begin
            ctrl_q  <= dec_ctrl;
            alu_q   <= dec_alu;
            shift_q <= dec_shift;
            pp_q    <= dec_pp;
            ill_q   <= !dec_legal;
            if (bus.opcode == OPW'(OP_LDM)) begin
              cnt   <= CW'(IMM_WORDS);
              state <= S_IMM;
            end else if (bus.opcode == OPW'(OP_RET) && RET_FLUSH > 0) begin
              cnt   <= CW'(RET_FLUSH);
              state <= S_FLUSH;
            end else if (bus.opcode == OPW'(OP_RTI) && RTI_FLUSH > 0) begin
              cnt   <= CW'(RTI_FLUSH);
              state <= S_FLUSH;
            end
          end
          S_IMM: if (bus.instr_valid) begin
            ctrl_q <= IMM_SIGNALS;
            alu_q  <= ALUW'(ALU_MOV);
            imm_q  <= 1'b1;
            cnt    <= cnt_dec;
            if (cnt <= ONE) state <= S_DECODE;
          end
          S_FLUSH: begin
            pch_q <= 1'b1;
            cnt   <= cnt_dec;
            if (cnt <= ONE) state <= S_DECODE;
          end
          default: state <= S_DECODE;
        endcase
      end
    end
  end

  assign bus.ctrl      = ctrl_q;
  assign bus.alu_op    = alu_q;
  assign bus.shift     = shift_q;
  assign bus.push_pop  = pp_q;
  assign bus.imm_phase = imm_q;
  assign bus.pc_hold   = pch_q;
  assign bus.illegal   = ill_q;
  assign bus.busy      = (state != S_DECODE);
  assign bus.flush_cnt = cnt;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: two builds share one stimulus stream and are each
// compared against a table-driven model counting immediate words and bubbles.
module tb_ctrl_sequencer;
  localparam logic [4:0] OP_NOP = 0, OP_SETC = 1, OP_CLRC = 2, OP_NOT = 3, OP_INC = 4, OP_DEC = 5;
  localparam logic [4:0] OP_OUT = 6, OP_IN = 7, OP_MOV = 8, OP_ADD = 9, OP_SUB = 10, OP_AND = 11;
  localparam logic [4:0] OP_OR = 12, OP_SHL = 13, OP_SHR = 14, OP_PUSH = 15, OP_POP = 16, OP_LDM = 17;
  localparam logic [4:0] OP_LDD = 18, OP_STD = 19, OP_JZ = 20, OP_JN = 21, OP_JC = 22, OP_JMP = 23;
  localparam logic [4:0] OP_CALL = 24, OP_RET = 25, OP_RTI = 26, OP_INT = 27, OP_RST = 28;
  localparam logic [3:0] A_NOP = 0, A_NOT = 1, A_INC = 2, A_DEC = 3, A_MOV = 4, A_ADD = 5, A_SUB = 6;
  localparam logic [3:0] A_AND = 7, A_OR = 8, A_SHL = 9, A_SHR = 10, A_LDD = 11, A_STD = 12;
  localparam logic [3:0] A_JMP = 13, A_SETC = 14;
  localparam logic [9:0] B_IR = 10'h200, B_IW = 10'h100, B_MR = 10'h080, B_MW = 10'h040, B_MTR = 10'h020;
  localparam logic [9:0] B_SRC = 10'h010, B_RW = 10'h008, B_BR = 10'h004, B_SETC = 10'h002, B_CLRC = 10'h001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b0;
  logic [4:0] op = '0;
  logic       valid = 1'b0, stl = 1'b0, nop = 1'b0, sq = 1'b0;

  ctrl_sequencer_if #(.OPW(5), .ALUW(4), .CW(2)) bus_a();
  ctrl_sequencer_if #(.OPW(5), .ALUW(4), .CW(1)) bus_b();

  assign bus_a.opcode = op;  assign bus_a.instr_valid = valid;
  assign bus_a.stall  = stl; assign bus_a.nop_in = nop; assign bus_a.squash = sq;
  assign bus_b.opcode = op;  assign bus_b.instr_valid = valid;
  assign bus_b.stall  = stl; assign bus_b.nop_in = nop; assign bus_b.squash = sq;

  ctrl_sequencer #(.OPW(5), .ALUW(4), .IMM_WORDS(2), .RET_FLUSH(2), .RTI_FLUSH(3))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  ctrl_sequencer #(.OPW(5), .ALUW(4), .IMM_WORDS(1), .RET_FLUSH(0), .RTI_FLUSH(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Opcode lookup table straight from the instruction list.
  typedef struct packed {
    logic       legal;
    logic [9:0] ctrl;
    logic [3:0] alu;
    logic       shift;
    logic [1:0] pp;
  } entry_t;
  entry_t tbl [32];

  function automatic void put(input logic [4:0] o, input logic [9:0] c, input logic [3:0] a,
                              input logic s, input logic [1:0] p);
    tbl[o] = '{legal: 1'b1, ctrl: c, alu: a, shift: s, pp: p};
  endfunction

  function automatic void fill_table();
    for (int i = 0; i < 32; i++) tbl[i] = '0;
    put(OP_NOT, B_RW, A_NOT, 0, 0);  put(OP_INC, B_RW, A_INC, 0, 0);  put(OP_DEC, B_RW, A_DEC, 0, 0);
    put(OP_MOV, B_RW, A_MOV, 0, 0);  put(OP_ADD, B_RW, A_ADD, 0, 0);  put(OP_SUB, B_RW, A_SUB, 0, 0);
    put(OP_AND, B_RW, A_AND, 0, 0);  put(OP_OR,  B_RW, A_OR,  0, 0);
    put(OP_SHL, B_RW, A_SHL, 1, 0);  put(OP_SHR, B_RW, A_SHR, 1, 0);
    put(OP_PUSH, B_MW, A_MOV, 0, 2'b01);
    put(OP_POP,  B_MR | B_MTR | B_RW, A_MOV, 0, 2'b11);
    put(OP_LDD,  B_MR | B_MTR | B_RW, A_LDD, 0, 0);
    put(OP_STD,  B_MW, A_STD, 0, 0);
    put(OP_JZ, B_BR, A_JMP, 0, 0);   put(OP_JN, B_BR, A_JMP, 0, 0);
    put(OP_JC, B_BR, A_JMP, 0, 0);   put(OP_JMP, B_BR, A_JMP, 0, 0);
    put(OP_CALL, B_BR, A_NOP, 0, 0); put(OP_INT, B_MW | B_BR, A_NOP, 0, 0);
    put(OP_OUT, B_IW, A_MOV, 0, 0);  put(OP_IN, B_IR | B_RW, A_MOV, 0, 0);
    put(OP_SETC, B_SETC, A_SETC, 0, 0); put(OP_CLRC, B_CLRC, A_NOP, 0, 0);
    put(OP_NOP, '0, A_NOP, 0, 0);    put(OP_RST, '0, A_NOP, 0, 0);   put(OP_LDM, '0, A_NOP, 0, 0);
    put(OP_RET, B_BR, A_NOP, 0, 0);  put(OP_RTI, B_BR, A_NOP, 0, 0);
  endfunction

  // Model: outputs plus "immediate words still owed" and "bubbles still owed".
  typedef struct {
    logic [9:0] ctrl;
    logic [3:0] alu;
    logic       shift;
    logic [1:0] pp;
    logic       imm;
    logic       pch;
    logic       ill;
    int         imm_left;
    int         bub;
  } mdl_t;
  mdl_t m [2];
  int p_imm [2] = '{2, 1};
  int p_ret [2] = '{2, 0};
  int p_rti [2] = '{3, 0};

  function automatic void set_nop(input int k);
    m[k].ctrl = '0; m[k].alu = A_NOP; m[k].shift = 0; m[k].pp = 0;
    m[k].imm = 0; m[k].pch = 0; m[k].ill = 0;
  endfunction

  function automatic void model_step(input int k);
    entry_t e;
    if (!rst) begin
      set_nop(k); m[k].imm_left = 0; m[k].bub = 0;
    end else if (sq) begin
      set_nop(k); m[k].imm_left = 0; m[k].bub = 0;
    end else if (stl) begin
      // everything holds
    end else if (nop) begin
      set_nop(k);
    end else if (m[k].imm_left > 0) begin
      set_nop(k);
      if (valid) begin
        m[k].ctrl = B_SRC | B_RW; m[k].alu = A_MOV; m[k].imm = 1;
        m[k].imm_left--;
      end
    end else if (m[k].bub > 0) begin
      set_nop(k); m[k].pch = 1; m[k].bub--;
    end else begin
      set_nop(k);
      if (valid) begin
        e = tbl[op];
        m[k].ctrl = e.ctrl; m[k].alu = e.alu; m[k].shift = e.shift; m[k].pp = e.pp;
        m[k].ill = !e.legal;
        if (op == OP_LDM) m[k].imm_left = p_imm[k];
        if (op == OP_RET) m[k].bub = p_ret[k];
        if (op == OP_RTI) m[k].bub = p_rti[k];
      end
    end
  endfunction

  task automatic check_outs(input int k, input string pfx, input logic [9:0] c, input logic [3:0] a,
                            input logic sh, input logic [1:0] pp, input logic im, input logic ph,
                            input logic bz, input logic il, input logic [1:0] fc);
    int exp_cnt;
    exp_cnt = (m[k].imm_left > 0) ? m[k].imm_left : m[k].bub;
    check({pfx, ".ctrl"},      32'(c),  32'(m[k].ctrl));
    check({pfx, ".alu_op"},    32'(a),  32'(m[k].alu));
    check({pfx, ".shift"},     32'(sh), 32'(m[k].shift));
    check({pfx, ".push_pop"},  32'(pp), 32'(m[k].pp));
    check({pfx, ".imm_phase"}, 32'(im), 32'(m[k].imm));
    check({pfx, ".pc_hold"},   32'(ph), 32'(m[k].pch));
    check({pfx, ".illegal"},   32'(il), 32'(m[k].ill));
    check({pfx, ".busy"},      32'(bz), 32'(m[k].imm_left > 0 || m[k].bub > 0));
    check({pfx, ".flush_cnt"}, 32'(fc), 32'(exp_cnt));
  endtask

  // Drive one cycle of inputs at the falling edge, then check at the next falling edge.
  task automatic cycle(input logic r, input logic [4:0] o, input logic v,
                       input logic s, input logic n, input logic q);
    rst = r; op = o; valid = v; stl = s; nop = n; sq = q;
    model_step(0);
    model_step(1);
    @(negedge clk);
    check_outs(0, "a", bus_a.ctrl, bus_a.alu_op, bus_a.shift, bus_a.push_pop, bus_a.imm_phase,
               bus_a.pc_hold, bus_a.busy, bus_a.illegal, bus_a.flush_cnt);
    check_outs(1, "b", bus_b.ctrl, bus_b.alu_op, bus_b.shift, bus_b.push_pop, bus_b.imm_phase,
               bus_b.pc_hold, bus_b.busy, bus_b.illegal, {1'b0, bus_b.flush_cnt});
  endtask

  task automatic go(input logic [4:0] o, input logic v);
    cycle(1'b1, o, v, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    fill_table();
    for (int k = 0; k < 2; k++) begin set_nop(k); m[k].imm_left = 0; m[k].bub = 0; end

    // Reset held with a valid ADD, then released.
    for (int i = 0; i < 3; i++) cycle(1'b0, OP_ADD, 1'b1, 1'b0, 1'b0, 1'b0);
    check("reset_busy", 32'(bus_a.busy), 32'd0);
    check("reset_alu", 32'(bus_a.alu_op), 32'(A_NOP));
    go(OP_ADD, 1'b1);
    check("add_ctrl", 32'(bus_a.ctrl), 32'(B_RW));
    check("add_alu", 32'(bus_a.alu_op), 32'(A_ADD));

    // LDM with two immediate words, then with a gap in the middle.
    go(OP_LDM, 1'b1);
    check("ldm_nop", 32'(bus_a.ctrl), 32'd0);
    check("ldm_busy", 32'(bus_a.busy), 32'd1);
    go(OP_NOP, 1'b1);
    check("imm1_phase", 32'(bus_a.imm_phase), 32'd1);
    check("imm1_busy", 32'(bus_a.busy), 32'd1);
    go(OP_NOP, 1'b1);
    check("imm2_phase", 32'(bus_a.imm_phase), 32'd1);
    check("imm2_busy", 32'(bus_a.busy), 32'd0);
    go(OP_LDM, 1'b1); go(OP_ADD, 1'b1); go(OP_ADD, 1'b0);
    check("gap_busy", 32'(bus_a.busy), 32'd1);
    go(OP_ADD, 1'b1); go(OP_SUB, 1'b1);

    // RTI: branch bundle then three bubbles.
    go(OP_RTI, 1'b1);
    check("rti_ctrl", 32'(bus_a.ctrl), 32'(B_BR));
    check("rti_cnt", 32'(bus_a.flush_cnt), 32'd3);
    for (int i = 2; i >= 0; i--) begin
      go(OP_ADD, 1'(i % 2));
      check("rti_bubble_hold", 32'(bus_a.pc_hold), 32'd1);
      check("rti_bubble_cnt", 32'(bus_a.flush_cnt), 32'(i));
    end
    go(OP_ADD, 1'b1);
    check("post_rti_hold", 32'(bus_a.pc_hold), 32'd0);
    check("post_rti_alu", 32'(bus_a.alu_op), 32'(A_ADD));

    // Squash at LDM word 1, and at flush bubble 2.
    go(OP_LDM, 1'b1);
    cycle(1'b1, OP_ADD, 1'b1, 1'b0, 1'b0, 1'b1);
    check("sq_imm_busy", 32'(bus_a.busy), 32'd0);
    go(OP_SHL, 1'b1);
    check("sq_imm_next", 32'(bus_a.shift), 32'd1);
    go(OP_RTI, 1'b1); go(OP_NOP, 1'b1);
    cycle(1'b1, OP_NOP, 1'b1, 1'b0, 1'b0, 1'b1);
    check("sq_flush_hold", 32'(bus_a.pc_hold), 32'd0);
    go(OP_POP, 1'b1);

    // Stall mid-flush, then stall together with squash.
    go(OP_RTI, 1'b1); go(OP_NOP, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, OP_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
      check("stall_cnt", 32'(bus_a.flush_cnt), 32'd2);
    end
    go(OP_NOP, 1'b1); go(OP_NOP, 1'b1);
    check("stall_last_hold", 32'(bus_a.pc_hold), 32'd1);
    go(OP_ADD, 1'b1);
    check("stall_after", 32'(bus_a.pc_hold), 32'd0);
    go(OP_RTI, 1'b1);
    cycle(1'b1, OP_NOP, 1'b1, 1'b1, 1'b0, 1'b1);
    check("stall_sq_busy", 32'(bus_a.busy), 32'd0);

    // Unmapped opcode, nop_in bubble, and RET on the zero-flush build.
    go(5'd31, 1'b1);
    check("illegal_pulse", 32'(bus_a.illegal), 32'd1);
    go(OP_ADD, 1'b1);
    check("illegal_clear", 32'(bus_a.illegal), 32'd0);
    cycle(1'b1, OP_ADD, 1'b1, 1'b0, 1'b1, 1'b0);
    go(OP_RET, 1'b1);
    check("ret0_ctrl", 32'(bus_b.ctrl), 32'(B_BR));
    check("ret0_busy", 32'(bus_b.busy), 32'd0);
    go(OP_PUSH, 1'b1);
    check("ret0_busy_next", 32'(bus_b.busy), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 99) != 0),
            5'($urandom_range(0, 31)),
            ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
